// File: rtl/mio_bus_responder.sv
// rtl/mio_bus_responder.sv - CPU_MIO bus responder: word RAM, GPIO and timer with programmable wait states
// Optional build macro: MIO_BUSERR_EN (sticky bus_err flag, 32'hDEAD_BEEF on unmapped reads)
module mio_bus_responder #(
    parameter int          ADDR_W      = 10,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] GPIO_ADDR   = 32'hF000_0000,
    parameter logic [31:0] TIMER_ADDR  = 32'hF000_0004
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        CPU_MIO,
    input  logic        mem_w,
    input  logic [31:0] Addr_in,
    input  logic [31:0] Data_from_cpu,
    output logic [31:0] Data_to_cpu,
    output logic        MIO_ready,
    output logic [31:0] gpio_out,
    output logic        bus_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_ACK  = 2'd2;

    localparam logic [3:0] WAIT_N    = 4'(WAIT_CYCLES);
    localparam logic [3:0] WAIT_LAST = WAIT_N - 4'd1;

    localparam int RAM_DEPTH = 1 << ADDR_W;

    logic [1:0]  state;
    logic [1:0]  state_next;
    logic [3:0]  wait_cnt;

    // captured request (word address only; byte lane bits are ignored)
    logic [31:2] addr_q;
    logic [31:0] data_q;
    logic        wr_q;

    // transaction currently being serviced: live bus in IDLE, captured copy afterwards
    logic [31:2] cur_addr;
    logic [31:0] cur_data;
    logic        cur_wr;

    logic        hit_ram;
    logic        hit_gpio;
    logic        hit_timer;
    logic [ADDR_W-1:0] ram_idx;

    logic        commit;
    logic [31:0] rd_data;
    logic [31:0] timer;

    logic [31:0] ram [RAM_DEPTH];

    // unmapped read value depends on the build
`ifdef MIO_BUSERR_EN
    localparam logic [31:0] UNMAPPED_RD = 32'hDEAD_BEEF;
`else
    localparam logic [31:0] UNMAPPED_RD = 32'h0000_0000;
`endif

    // select between the live bus (acceptance cycle) and the captured request
    always_comb begin
        cur_addr = addr_q;
        cur_data = data_q;
        cur_wr   = wr_q;
        if (state == S_IDLE) begin
            cur_addr = Addr_in[31:2];
            cur_data = Data_from_cpu;
            cur_wr   = mem_w;
        end
    end

    // address decode of the active transaction
    always_comb begin
        hit_ram   = (cur_addr[31:ADDR_W+2] == '0);
        hit_gpio  = (cur_addr == GPIO_ADDR[31:2]);
        hit_timer = (cur_addr == TIMER_ADDR[31:2]);
        ram_idx   = cur_addr[ADDR_W+1:2];
    end

    // next-state logic; WAIT_CYCLES==0 jumps straight from IDLE to ACK
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (CPU_MIO) begin
                    state_next = (WAIT_N == 4'd0) ? S_ACK : S_WAIT;
                end
            end
            S_WAIT: begin
                if (wait_cnt == WAIT_LAST) begin
                    state_next = S_ACK;
                end
            end
            S_ACK:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // targets are updated on the edge that enters ACK; reset on that edge discards the access
    assign commit = (state_next == S_ACK) && !reset;

    // read data multiplexer, evaluated at the commit edge
    always_comb begin
        rd_data = UNMAPPED_RD;
        if (hit_ram) begin
            rd_data = ram[ram_idx];
        end else if (hit_gpio) begin
            rd_data = gpio_out;
        end else if (hit_timer) begin
            rd_data = timer;
        end
    end

    // state register, wait counter and registered acknowledge
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            wait_cnt  <= 4'd0;
            MIO_ready <= 1'b0;
        end else begin
            state     <= state_next;
            MIO_ready <= (state_next == S_ACK);
            if (state == S_WAIT && state_next == S_WAIT) begin
                wait_cnt <= wait_cnt + 4'd1;
            end else begin
                wait_cnt <= 4'd0;
            end
        end
    end

    // request capture; bus inputs are only sampled while IDLE
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q <= '0;
            data_q <= '0;
            wr_q   <= 1'b0;
        end else if (state == S_IDLE && CPU_MIO) begin
            addr_q <= Addr_in[31:2];
            data_q <= Data_from_cpu;
            wr_q   <= mem_w;
        end
    end

    // word RAM write port; contents survive reset
    always_ff @(posedge clk) begin
        if (commit && cur_wr && hit_ram) begin
            ram[ram_idx] <= cur_data;
        end
    end

    // GPIO output register
    always_ff @(posedge clk) begin
        if (reset) begin
            gpio_out <= '0;
        end else if (commit && cur_wr && hit_gpio) begin
            gpio_out <= cur_data;
        end
    end

    // free-running timer; a CPU write overrides the increment in that cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            timer <= '0;
        end else if (commit && cur_wr && hit_timer) begin
            timer <= cur_data;
        end else begin
            timer <= timer + 32'd1;
        end
    end

    // read data returned to the CPU; holds across writes until the next read ACK
    always_ff @(posedge clk) begin
        if (reset) begin
            Data_to_cpu <= '0;
        end else if (commit && !cur_wr) begin
            Data_to_cpu <= rd_data;
        end
    end

`ifdef MIO_BUSERR_EN
    // sticky flag for any accepted access that hits no target
    always_ff @(posedge clk) begin
        if (reset) begin
            bus_err <= 1'b0;
        end else if (commit && !(hit_ram || hit_gpio || hit_timer)) begin
            bus_err <= 1'b1;
        end
    end
`else
    assign bus_err = 1'b0;
`endif

endmodule
